// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared types and modelling-style names for the fixed-point arithmetic IP
package fixed_point_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} serial_add_state_e;
  localparam string MODEL_BEHAVIORAL = "Behavioral";
  localparam string MODEL_DATAFLOW = "DataFlow";
  localparam string MODEL_STRUCTURAL = "Structural";
endpackage

// File: rtl/serial_add_cell.sv
// serial_full_add_cell: 1-bit full adder built from two half adders in a selectable modelling style
module half_add
  import fixed_point_pkg::*;
#(
  parameter string MODEL = MODEL_BEHAVIORAL
) (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  if (MODEL == MODEL_STRUCTURAL) begin : g_struct
    xor u_xor (s, a, b);
    and u_and (co, a, b);
  end else if (MODEL == MODEL_DATAFLOW) begin : g_dataflow
    assign s = a ^ b;
    assign co = a & b;
  end else begin : g_behav
    // two-bit sum of the operands gives carry and sum together
    always_comb {co, s} = {1'b0, a} + {1'b0, b};
  end
endmodule

module serial_full_add_cell
  import fixed_point_pkg::*;
#(
  parameter string MODEL = MODEL_BEHAVIORAL
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_s0, w_c0, w_c1;
  half_add #(.MODEL(MODEL)) u_ha0 (.a(a), .b(b), .s(w_s0), .co(w_c0));
  half_add #(.MODEL(MODEL)) u_ha1 (.a(w_s0), .b(ci), .s(s), .co(w_c1));
  assign co = w_c0 | w_c1;
endmodule

// File: rtl/serial_add.sv
// serial_add: bit-serial two's complement adder, one bit per clock, valid/ready on both sides
module serial_add
  import fixed_point_pkg::*;
#(
  parameter int    WIDTH = 16,
  parameter string MODEL = MODEL_BEHAVIORAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             co,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  serial_add_state_e r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_c;
  logic [CW-1:0] r_cnt;
  logic r_carry, r_co, r_ovf;
  logic w_s, w_co, w_accept, w_last;
  serial_full_add_cell #(.MODEL(MODEL)) u_cell (
    .a(r_a[0]), .b(r_b[0]), .ci(r_carry), .s(w_s), .co(w_co)
  );
  assign c = r_c;
  assign co = r_co;
  assign ovf = r_ovf;
  // handshake outputs and next state; DONE can hand straight over to a new operation
  always_comb begin
    in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    out_valid = r_state == DONE;
    w_accept = in_valid & in_ready;
    w_last = r_cnt == LAST;
    w_next = w_accept ? RUN
           : (r_state == RUN) ? (w_last ? DONE : RUN)
           : ((r_state == DONE) & out_ready) ? IDLE
           : r_state;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // operand capture, LSB-first shifting and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_cnt <= '0;
      r_carry <= 1'b0;
      r_co <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_a <= a;
      r_b <= b;
      r_carry <= ci;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
      r_c <= {w_s, r_c[WIDTH-1:1]};
      r_carry <= w_co;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_co <= w_co;
        r_ovf <= r_carry ^ w_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: directed checks of serial_add at WIDTH=8 across all three cell modelling styles
module tb_serial_add;
  import fixed_point_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, ci;
  logic [7:0] a, b;
  logic in_ready_w [3];
  logic out_valid_w [3];
  logic co_w [3];
  logic ovf_w [3];
  logic [7:0] c_w [3];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  serial_add #(.WIDTH(8), .MODEL(MODEL_BEHAVIORAL)) u_beh (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .a(a), .b(b), .ci(ci),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .c(c_w[0]), .co(co_w[0]), .ovf(ovf_w[0])
  );
  serial_add #(.WIDTH(8), .MODEL(MODEL_DATAFLOW)) u_df (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .a(a), .b(b), .ci(ci),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .c(c_w[1]), .co(co_w[1]), .ovf(ovf_w[1])
  );
  serial_add #(.WIDTH(8), .MODEL(MODEL_STRUCTURAL)) u_st (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]), .a(a), .b(b), .ci(ci),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .c(c_w[2]), .co(co_w[2]), .ovf(ovf_w[2])
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(input string tag, input logic [7:0] ec, input logic eco, input logic eovf,
                           input logic eov, input logic eir);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("%s.c[%0d]", tag, m), 64'(c_w[m]), 64'(ec));
      check($sformatf("%s.co[%0d]", tag, m), 64'(co_w[m]), 64'(eco));
      check($sformatf("%s.ovf[%0d]", tag, m), 64'(ovf_w[m]), 64'(eovf));
      check($sformatf("%s.out_valid[%0d]", tag, m), 64'(out_valid_w[m]), 64'(eov));
      check($sformatf("%s.in_ready[%0d]", tag, m), 64'(in_ready_w[m]), 64'(eir));
    end
  endtask
  task automatic ref_add(input logic [7:0] x, input logic [7:0] y, input logic cin,
                         output logic [7:0] ec, output logic eco, output logic eovf);
    logic [8:0] sum;
    sum = {1'b0, x} + {1'b0, y} + {8'd0, cin};
    ec = sum[7:0];
    eco = sum[8];
    eovf = (x[7] == y[7]) && (ec[7] != x[7]);
  endtask
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!out_valid_w[0] && n < 40) begin
      for (int m = 0; m < 3; m++) check($sformatf("%s.run_in_ready[%0d]", tag, m), 64'(in_ready_w[m]), 64'(0));
      tick;
      n++;
    end
    if (!out_valid_w[0]) check({tag, ".timeout"}, 64'(0), 64'(1));
  endtask
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic cin, input int hold);
    logic [7:0] ec;
    logic eco, eovf;
    int n;
    ref_add(x, y, cin, ec, eco, eovf);
    a = x;
    b = y;
    ci = cin;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    a = ~x;
    b = x ^ y;
    ci = ~cin;
    wait_valid(tag, n);
    check({tag, ".latency"}, 64'(n), 64'(8));
    check_all({tag, ".result"}, ec, eco, eovf, 1'b1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick;
      check_all($sformatf("%s.hold%0d", tag, i), ec, eco, eovf, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_all({tag, ".idle"}, ec, eco, eovf, 1'b0, 1'b1);
  endtask
  initial begin
    logic [7:0] ec;
    logic eco, eovf;
    int n1, n2;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    ci = 1'b0;
    repeat (2) tick;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick;
    run_op("t1_7f_01", 8'h7F, 8'h01, 1'b0, 0);
    check("t1_c_const", 64'(c_w[0]), 64'(8'h80));
    run_op("t2_ff_01", 8'hFF, 8'h01, 1'b0, 0);
    run_op("t2_ff_00_ci", 8'hFF, 8'h00, 1'b1, 0);
    run_op("t3_80_80", 8'h80, 8'h80, 1'b0, 5);
    a = 8'h12;
    b = 8'h34;
    ci = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick;
    a = 8'h05;
    b = 8'h0A;
    wait_valid("t4_first", n1);
    check_all("t4_first", 8'h46, 1'b0, 1'b0, 1'b1, 1'b1);
    tick;
    a = 8'hEE;
    b = 8'hEE;
    wait_valid("t4_second", n2);
    check("t4_gap", 64'(n2 + 1), 64'(9));
    check_all("t4_second", 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    check_all("t4_idle", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
    a = 8'h55;
    b = 8'hAA;
    ci = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    #2;
    rst = 1'b1;
    #1;
    check_all("t5_rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    rst = 1'b0;
    tick;
    check_all("t5_after_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("t5_01_02", 8'h01, 8'h02, 1'b0, 0);
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      run_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
    ref_add(8'hC0, 8'hC0, 1'b1, ec, eco, eovf);
    check("model_c0", 64'({eco, eovf, ec}), 64'({1'b1, 1'b0, 8'h81}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
